// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers.
// Ports: clock, reset (sync, active-low), start/op/operand_a/operand_b
//   launch an operation; hi_write/lo_write load HI/LO from operand_a
//   while idle; busy stalls the CPU; done pulses once with HI/LO valid.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  hi_write,
  input  logic                  lo_write,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W = DATA_WIDTH;
  localparam logic [5:0] LAST = 6'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           done_q, done_d;
  // acc: product upper half / remainder
  // wrk: multiplier+product lower half / dividend+quotient
  // mag: multiplicand magnitude / divisor magnitude
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   wrk_q, wrk_d;
  logic [W-1:0]   mag_q, mag_d;
  logic [W-1:0]   raw_a_q, raw_a_d;
  logic           is_div_q, is_div_d;
  logic           neg_q, neg_d;
  logic           neg_rem_q, neg_rem_d;
  logic           div0_q, div0_d;

  logic           a_neg, b_neg;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     sum;
  logic [W:0]     trial;
  logic           fits;
  logic [W-1:0]   diff;
  logic [W-1:0]   rem_next;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_neg;

  // op[0]==0 selects the signed variants
  assign a_neg = !op[0] && operand_a[W-1];
  assign b_neg = !op[0] && operand_b[W-1];
  assign mag_a = a_neg ? -operand_a : operand_a;
  assign mag_b = b_neg ? -operand_b : operand_b;

  // shift-add step; the carry rides into the shifted-in bit
  assign sum = {1'b0, acc_q}
             + (wrk_q[0] ? {1'b0, mag_q} : '0);

  // restoring step; trial < 2*divisor so W bits of diff suffice
  assign trial    = {acc_q, wrk_q[W-1]};
  assign fits     = trial >= {1'b0, mag_q};
  assign diff     = trial[W-1:0] - mag_q;
  assign rem_next = fits ? diff : trial[W-1:0];

  assign prod     = {acc_q, wrk_q};
  assign prod_neg = -prod;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
    wrk_d     = wrk_q;
    mag_d     = mag_q;
    raw_a_d   = raw_a_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = op[1] && (operand_b == '0);
          raw_a_d   = operand_a;
          acc_d     = '0;
          if (op[1]) begin
            wrk_d = mag_a;
            mag_d = mag_b;
          end else begin
            wrk_d = mag_b;
            mag_d = mag_a;
          end
        end else begin
          if (hi_write) hi_d = operand_a;
          if (lo_write) lo_d = operand_a;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_d = rem_next;
          wrk_d = {wrk_q[W-2:0], fits};
        end else begin
          acc_d = sum[W:1];
          wrk_d = {sum[0], wrk_q[W-1:1]};
        end
        if (cnt_q == LAST) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (div0_q) begin
          hi_d = raw_a_q;
          lo_d = '1;
        end else if (is_div_q) begin
          lo_d = neg_q ? -wrk_q : wrk_q;
          hi_d = neg_rem_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      wrk_q     <= '0;
      mag_q     <= '0;
      raw_a_q   <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
      wrk_q     <= wrk_d;
      mag_q     <= mag_d;
      raw_a_q   <= raw_a_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// Stimulus pushes expected HI/LO; a monitor pops on each done pulse.
module tb_muldiv_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        hi_write = 1'b0;
  logic        lo_write = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          t0;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;
  logic done_prev = 1'b0;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .hi_write  (hi_write),
    .lo_write  (lo_write),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest expectation
  always @(negedge clock) begin
    if (reset && done) begin
      chk("done_width", {31'b0, done_prev}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_hi"}, hi, e.hi);
        chk({e.nm, "_lo"}, lo, e.lo);
        chk({e.nm, "_lat"}, 32'(cyc - e.t0), 32'd33);
      end
    end
    done_prev = done;
  end

  // call at a negedge; start is sampled at the next posedge
  task automatic launch(logic [1:0] o, logic [31:0] a,
                        logic [31:0] b, logic [31:0] eh,
                        logic [31:0] el, string nm);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    @(posedge clock);
    #1;
    sb.push_back('{hi: eh, lo: el, t0: cyc, nm: nm});
    start     = 1'b0;
    operand_a = 32'h0F0F_0F0F;
    operand_b = 32'h0000_0003;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clock);
    while (!done && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("done_timeout", {31'b0, done}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;

    @(negedge clock);
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    repeat (30) @(negedge clock);
    chk("run_busy", {31'b0, busy}, 32'd1);
    chk("run_hold_lo", lo, 32'd0);
    wait_idle();

    @(negedge clock);
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
    wait_idle();
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    wait_idle();
    launch(OP_DIV, 32'd20, 32'hFFFF_FFFD,
           32'd2, 32'hFFFF_FFFA, "div_negb");
    wait_idle();
    launch(OP_MULT, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 32'h0, "mult_min");
    wait_idle();
    launch(OP_DIVU, 32'h1234_5678, 32'd0,
           32'h1234_5678, 32'hFFFF_FFFF, "divu_zero");
    wait_idle();
    launch(OP_DIV, 32'hFFFF_FFF0, 32'd0,
           32'hFFFF_FFF0, 32'hFFFF_FFFF, "div_zero");
    wait_idle();
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 32'h8000_0000, "div_ovf");
    wait_idle();

    hi_write  = 1'b1;
    operand_a = 32'hAAAA_0000;
    @(negedge clock);
    hi_write  = 1'b0;
    chk("mthi", hi, 32'hAAAA_0000);
    lo_write  = 1'b1;
    operand_a = 32'h0000_5555;
    @(negedge clock);
    lo_write  = 1'b0;
    chk("mtlo", lo, 32'h0000_5555);
    chk("mtlo_hi_kept", hi, 32'hAAAA_0000);
    hi_write  = 1'b1;
    lo_write  = 1'b1;
    operand_a = 32'h0BAD_F00D;
    @(negedge clock);
    hi_write  = 1'b0;
    lo_write  = 1'b0;
    chk("mt_both_hi", hi, 32'h0BAD_F00D);
    chk("mt_both_lo", lo, 32'h0BAD_F00D);

    launch(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "multu_2x3");
    repeat (5) @(negedge clock);
    hi_write  = 1'b1;
    lo_write  = 1'b1;
    operand_a = 32'hDEAD_BEEF;
    @(negedge clock);
    hi_write  = 1'b0;
    lo_write  = 1'b0;
    chk("busy_mthi", hi, 32'h0BAD_F00D);
    chk("busy_mtlo", lo, 32'h0BAD_F00D);
    wait_idle();

    hi_write = 1'b1;
    lo_write = 1'b1;
    launch(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");
    hi_write = 1'b0;
    lo_write = 1'b0;
    @(negedge clock);
    chk("start_wins_hi", hi, 32'd0);
    chk("start_wins_lo", lo, 32'd6);
    repeat (3) @(negedge clock);
    start     = 1'b1;
    op        = OP_MULT;
    operand_a = 32'd3;
    operand_b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clock);

    start     = 1'b1;
    op        = OP_MULTU;
    operand_a = 32'd5;
    operand_b = 32'd6;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    reset = 1'b1;
    repeat (40) @(negedge clock);

    launch(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, "multu_5x6");
    wait_done();
    launch(OP_MULTU, 32'h0001_0000, 32'h0001_0000,
           32'd1, 32'd0, "b2b_multu");
    wait_idle();

    for (int n = 0; n < 200 && sb.size() != 0; n++)
      @(negedge clock);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
